imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_ram.sv | 16 +
 rtl/imem_loader.sv | 57 +++++
 tb/tb_imem_loader.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encodings, default depth, fill value and output decode
package imem_loader_pkg;
    typedef enum logic [1:0] {LOAD = 2'd0, DONE = 2'd1, ERR = 2'd2} state_t;
    localparam int DEFAULT_DEPTH = 64;
    localparam logic [31:0] FILL = 32'h00000000;
    // {cpu_hold, load_done, error} for a given state
    function automatic logic [2:0] flags(state_t s);
        return {s != DONE, s == DONE, s == ERR};
    endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream into the loader (s_data/s_valid/s_last from master, s_ready back)
interface imem_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    modport master(output s_data, s_valid, s_last, input s_ready);
    modport slave(input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/imem_ram.sv
// imem_ram: DEPTH_WORDS x 32 array, sync write (we/waddr/wdata), async read (raddr -> rdata)
module imem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    always_ff @(posedge CLK) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into instruction memory and gates CPU fetches until loaded
// Ports: CLK/Reset (sync, active-high); s = byte stream slave; Address -> Data fetch path;
// load_done/cpu_hold/error status; word_count = words written.
module imem_loader import imem_loader_pkg::*; #(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH,
    parameter int AW          = 6
) (
    input  logic         CLK,
    input  logic         Reset,
    imem_loader_if.slave s,
    input  logic [63:0]  Address,
    output logic [31:0]  Data,
    output logic         load_done,
    output logic         cpu_hold,
    output logic         error,
    output logic [AW:0]  word_count
);
    state_t      state_q, state_d;
    logic [1:0]  idx_q;
    logic [23:0] asm_q;
    logic [AW:0] wc_q;
    logic [2:0]  flags_q;
    logic        accept, we, full;
    logic [31:0] rdata;
    assign s.s_ready = state_q == LOAD && !Reset;
    assign accept    = s.s_valid && s.s_ready;
    assign we        = accept && idx_q == 2'd3;
    assign full      = wc_q[AW-1:0] == AW'(DEPTH_WORDS - 1);
    always_comb state_d = !accept ? state_q :
                          s.s_last ? (idx_q == 2'd3 ? DONE : ERR) :
                          (we && full) ? ERR : LOAD;
    // bytes shift in from the top so byte k sits at [8k+7:8k] once the fourth arrives
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= LOAD;
            idx_q   <= '0;
            wc_q    <= '0;
            flags_q <= flags(LOAD);
        end else begin
            state_q <= state_d;
            flags_q <= flags(state_d);
            if (accept) begin
                idx_q <= idx_q + 2'd1;
                asm_q <= {s.s_data, asm_q[23:8]};
            end
            if (we) wc_q <= wc_q + 1'b1;
        end
    end
    imem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .CLK(CLK), .we(we), .waddr(wc_q[AW-1:0]), .wdata({s.s_data, asm_q}),
        .raddr(Address[AW+1:2]), .rdata(rdata)
    );
    assign {cpu_hold, load_done, error} = flags_q;
    assign word_count = wc_q;
    assign Data = (flags_q[1] && Address[1:0] == 2'b00 && Address[63:AW+2] == '0 &&
                   {1'b0, Address[AW+1:2]} < wc_q) ? rdata : FILL;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader (64-word and 4-word instances)
module tb_imem_loader;
    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] data;
        logic        done, hold, err, rdy;
        logic [6:0]  wc;
    } exp_t;

    logic        CLK = 0;
    logic        Reset;
    logic [63:0] Address;
    logic        probe;
    logic [31:0] d64, d4;
    logic        done64, hold64, err64, done4, hold4, err4;
    logic [6:0]  wc64;
    logic [2:0]  wc4;
    exp_t        q[$];
    int          vec = 0;
    int          miss = 0;

    always #5 CLK = ~CLK;

    imem_loader_if i64();
    imem_loader_if i4();

    imem_loader dut (
        .CLK(CLK), .Reset(Reset), .s(i64), .Address(Address), .Data(d64),
        .load_done(done64), .cpu_hold(hold64), .error(err64), .word_count(wc64)
    );
    imem_loader #(.DEPTH_WORDS(4), .AW(2)) dut4 (
        .CLK(CLK), .Reset(Reset), .s(i4), .Address(Address), .Data(d4),
        .load_done(done4), .cpu_hold(hold4), .error(err4), .word_count(wc4)
    );

    always @(negedge CLK) begin : mon
        exp_t        e;
        logic [31:0] d;
        logic        dn, h, er, r;
        logic [6:0]  w;
        if (probe) begin
            if (q.size() == 0) begin
                miss++;
                $display("FAIL monitor: output probed with empty scoreboard");
            end else begin
                e  = q.pop_front();
                vec++;
                d  = e.sel ? d4 : d64;
                dn = e.sel ? done4 : done64;
                h  = e.sel ? hold4 : hold64;
                er = e.sel ? err4 : err64;
                r  = e.sel ? i4.s_ready : i64.s_ready;
                w  = e.sel ? {4'b0, wc4} : wc64;
                if (d !== e.data || dn !== e.done || h !== e.hold || er !== e.err ||
                    r !== e.rdy || w !== e.wc) begin
                    miss++;
                    $display("FAIL %s: got data=%h done=%b hold=%b err=%b rdy=%b wc=%0d, want data=%h done=%b hold=%b err=%b rdy=%b wc=%0d",
                             e.name, d, dn, h, er, r, w, e.data, e.done, e.hold, e.err, e.rdy, e.wc);
                end
            end
        end
    end

    task automatic send(input bit sel, input logic [7:0] b, input bit last, input int gap);
        if (sel) begin
            i4.s_data = b; i4.s_last = last; i4.s_valid = 1;
        end else begin
            i64.s_data = b; i64.s_last = last; i64.s_valid = 1;
        end
        @(posedge CLK); #1;
        i4.s_valid = 0; i64.s_valid = 0; i4.s_last = 0; i64.s_last = 0;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        Reset = 1;
        @(posedge CLK); #1;
        Reset = 0;
    endtask

    task automatic chk(input string n, input bit sel, input logic [63:0] a, input logic [31:0] d,
                       input logic dn, input logic h, input logic er, input logic r, input logic [6:0] w);
        exp_t e;
        Address = a;
        e.name = n; e.sel = sel; e.data = d; e.done = dn; e.hold = h; e.err = er; e.rdy = r; e.wc = w;
        q.push_back(e);
        probe = 1;
        @(negedge CLK); #1;
        probe = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1; probe = 0; Address = 0;
        i64.s_valid = 0; i64.s_last = 0; i64.s_data = 0;
        i4.s_valid = 0;  i4.s_last = 0;  i4.s_data = 0;
        @(posedge CLK); #1;
        chk("reset64", 0, 0, 0, 0, 1, 0, 0, 0);
        chk("reset4",  1, 0, 0, 0, 1, 0, 0, 0);
        Reset = 0;
        chk("idle", 0, 0, 0, 0, 1, 0, 1, 0);
        // single word load
        send(0, 8'hE9, 0, 0); send(0, 8'h03, 0, 0); send(0, 8'h40, 0, 0); send(0, 8'hF8, 1, 0);
        chk("load_a0",  0, 64'h0,   32'hF84003E9, 1, 0, 0, 0, 1);
        chk("load_a4",  0, 64'h4,   32'h0,        1, 0, 0, 0, 1);
        chk("misalign", 0, 64'h2,   32'h0,        1, 0, 0, 0, 1);
        chk("oor_100",  0, 64'h100, 32'h0,        1, 0, 0, 0, 1);
        chk("oor_hi",   0, 64'h8000_0000_0000_0000, 32'h0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) send(0, 8'h11, 1, 0);
        chk("done_sticky", 0, 64'h0, 32'hF84003E9, 1, 0, 0, 0, 1);
        // two words with idle gaps
        do_reset();
        send(0, 8'hE9, 0, 3); send(0, 8'h03, 0, 3); send(0, 8'h40, 0, 3); send(0, 8'hF8, 0, 3);
        chk("gap_mid", 0, 64'h0, 32'h0, 0, 1, 0, 1, 1);
        send(0, 8'hEA, 0, 3); send(0, 8'h83, 0, 3); send(0, 8'h40, 0, 3); send(0, 8'hF8, 1, 3);
        chk("gap_w0", 0, 64'h0, 32'hF84003E9, 1, 0, 0, 0, 2);
        chk("gap_w1", 0, 64'h4, 32'hF84083EA, 1, 0, 0, 0, 2);
        chk("gap_a8", 0, 64'h8, 32'h0,        1, 0, 0, 0, 2);
        // partial last word
        do_reset();
        send(0, 8'h09, 0, 0); send(0, 8'hDE, 1, 0);
        chk("partial", 0, 64'h0, 32'h0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) send(0, 8'h55, i == 3, 0);
        chk("err_sticky", 0, 64'h0, 32'h0, 0, 1, 1, 0, 0);
        // reset mid-word
        do_reset();
        send(0, 8'hAA, 0, 0); send(0, 8'hBB, 0, 0);
        do_reset();
        send(0, 8'h29, 0, 0); send(0, 8'h01, 0, 0); send(0, 8'h0A, 0, 0); send(0, 8'hAA, 1, 0);
        chk("midrst_a0", 0, 64'h0, 32'hAA0A0129, 1, 0, 0, 0, 1);
        chk("stale_a4",  0, 64'h4, 32'h0,        1, 0, 0, 0, 1);
        // overflow on 4-word instance
        do_reset();
        for (int i = 0; i < 12; i++) send(1, 8'(i), 0, 0);
        chk("ovf_12", 1, 64'h0, 32'h0, 0, 1, 0, 1, 3);
        for (int i = 12; i < 16; i++) send(1, 8'(i), 0, 0);
        chk("ovf_16", 1, 64'h0, 32'h0, 0, 1, 1, 0, 4);
        // exact fill with s_last on the final byte
        do_reset();
        for (int i = 0; i < 16; i++) send(1, 8'(i), i == 15, 0);
        chk("fill_a12", 1, 64'hC,  32'h0F0E0D0C, 1, 0, 0, 0, 4);
        chk("fill_a0",  1, 64'h0,  32'h03020100, 1, 0, 0, 0, 4);
        chk("fill_a16", 1, 64'h10, 32'h0,        1, 0, 0, 0, 4);
        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
            miss += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
